// File: rtl/pll_pkg.sv
// Shared definitions for the PLL bring-up controller: state encoding,
// default parameter values and the retry counter width.
package pll_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRST,
        WAIT,
        FILT,
        REL,
        RUN,
        FAIL
    } state_t;

    localparam int unsigned DEF_NUM_OUT        = 2;
    localparam int unsigned DEF_RST_CYCLES     = 16;
    localparam int unsigned DEF_FILTER_CYCLES  = 64;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 65536;
    localparam int unsigned DEF_MAX_RETRIES    = 3;
    localparam int unsigned DEF_STAGGER_CYCLES = 4;

    localparam int unsigned RETRY_W = 4;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for one asynchronous bit; resets to 0.
module sync2 (
    input  logic clki,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clki or negedge rstn) begin
        if (!rstn) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_ctrl.sv
// PLL bring-up controller: pulses PLL reset, filters LOCKED, retries on
// timeout and releases the downstream channel resets one after another.
module pll_ctrl
    import pll_pkg::*;
#(
    parameter int unsigned NUM_OUT        = DEF_NUM_OUT,
    parameter int unsigned RST_CYCLES     = DEF_RST_CYCLES,
    parameter int unsigned FILTER_CYCLES  = DEF_FILTER_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned MAX_RETRIES    = DEF_MAX_RETRIES,
    parameter int unsigned STAGGER_CYCLES = DEF_STAGGER_CYCLES
) (
    input  logic               clki,
    input  logic               rstn,
    input  logic               en,
    input  logic               pll_locked,
    input  logic               clr_lost,
    output logic               pll_rst,
    output logic               pll_pwrdwn,
    output logic [NUM_OUT-1:0] chan_rst_n,
    output logic               ready,
    output logic               fail,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic               lock_lost
);

    localparam int unsigned REL_LAST = STAGGER_CYCLES * (NUM_OUT - 1) + 1;
    localparam int unsigned RST_W    = $clog2(RST_CYCLES) + 1;
    localparam int unsigned FLT_W    = $clog2(FILTER_CYCLES) + 1;
    localparam int unsigned TO_W     = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int unsigned REL_W    = $clog2(REL_LAST) + 1;

    state_t             state;
    logic               locked_s;
    logic [RST_W-1:0]   rst_cnt;
    logic [FLT_W-1:0]   flt_cnt;
    logic [TO_W-1:0]    to_cnt;
    logic [REL_W-1:0]   rel_cnt;
    logic [NUM_OUT-1:0] rel_hit;

    sync2 u_sync (
        .clki (clki),
        .rstn (rstn),
        .d    (pll_locked),
        .q    (locked_s)
    );

    // Channel g is due for release when the REL counter reaches g*STAGGER.
    for (genvar g = 0; g < NUM_OUT; g++) begin : g_rel
        assign rel_hit[g] = (rel_cnt == REL_W'(STAGGER_CYCLES * g));
    end

    always_ff @(posedge clki or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            pll_rst    <= 1'b1;
            pll_pwrdwn <= 1'b1;
            chan_rst_n <= '0;
            ready      <= 1'b0;
            fail       <= 1'b0;
            retry_cnt  <= '0;
            lock_lost  <= 1'b0;
            rst_cnt    <= '0;
            flt_cnt    <= '0;
            to_cnt     <= '0;
            rel_cnt    <= '0;
        end else begin
            if (clr_lost) begin
                lock_lost <= 1'b0;
            end
            if (!en) begin
                state      <= IDLE;
                pll_rst    <= 1'b1;
                pll_pwrdwn <= 1'b1;
                chan_rst_n <= '0;
                ready      <= 1'b0;
                fail       <= 1'b0;
                retry_cnt  <= '0;
                rst_cnt    <= '0;
                flt_cnt    <= '0;
                to_cnt     <= '0;
                rel_cnt    <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        state      <= PRST;
                        pll_rst    <= 1'b1;
                        pll_pwrdwn <= 1'b0;
                        rst_cnt    <= '0;
                    end
                    PRST: begin
                        if (rst_cnt == RST_W'(RST_CYCLES - 1)) begin
                            state   <= WAIT;
                            pll_rst <= 1'b0;
                            to_cnt  <= '0;
                        end else if (rst_cnt != '1) begin
                            rst_cnt <= rst_cnt + RST_W'(1);
                        end
                    end
                    WAIT, FILT: begin
                        if (to_cnt != '1) begin
                            to_cnt <= to_cnt + TO_W'(1);
                        end
                        if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                            flt_cnt <= '0;
                            pll_rst <= 1'b1;
                            if (retry_cnt == RETRY_W'(MAX_RETRIES)) begin
                                state      <= FAIL;
                                pll_pwrdwn <= 1'b1;
                                fail       <= 1'b1;
                            end else begin
                                state     <= PRST;
                                retry_cnt <= retry_cnt + RETRY_W'(1);
                                rst_cnt   <= '0;
                            end
                        end else if (!locked_s) begin
                            state   <= WAIT;
                            flt_cnt <= '0;
                        end else if (state == WAIT) begin
                            state   <= FILT;
                            flt_cnt <= '0;
                        end else if (flt_cnt == FLT_W'(FILTER_CYCLES - 1)) begin
                            state   <= REL;
                            rel_cnt <= '0;
                        end else if (flt_cnt != '1) begin
                            flt_cnt <= flt_cnt + FLT_W'(1);
                        end
                    end
                    REL, RUN: begin
                        if (!locked_s) begin
                            // Lock dropped: pull everything down and restart the PLL.
                            state      <= PRST;
                            pll_rst    <= 1'b1;
                            chan_rst_n <= '0;
                            ready      <= 1'b0;
                            lock_lost  <= 1'b1;
                            retry_cnt  <= '0;
                            rst_cnt    <= '0;
                        end else if (state == REL) begin
                            chan_rst_n <= chan_rst_n | rel_hit;
                            if (rel_cnt == REL_W'(REL_LAST)) begin
                                state <= RUN;
                                ready <= 1'b1;
                            end
                            if (rel_cnt != '1) begin
                                rel_cnt <= rel_cnt + REL_W'(1);
                            end
                        end
                    end
                    FAIL: begin
                        state <= FAIL;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
